neo_led_scan: RTL and testbench

MVS cabinet credit-display and EL-lamp controller. It sits behind the NEO-F0 LED latch/data registers and captures LED_DATA whenever a LED_LATCH strobe bit falls. It then drives a 4-digit multiplexed 7-segment display (two 2-digit credit counters) plus a 4-bit EL/marquee lamp output. Console builds tie SYSTEM_TYPE low, which holds every output dark.

---
 rtl/neo_led_scan.sv | 130 +++++++++++++
 tb/tb_neo_led_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/neo_led_scan.sv
// MVS credit-display / EL-lamp controller behind the NEO-F0 LED latches.
// Define LED_HEX_EN to decode nibbles A-F as hex glyphs; otherwise A-F are blank.
module neo_led_scan #(
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 4
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       SYSTEM_TYPE,
  input  logic [2:0] LED_LATCH,
  input  logic [7:0] LED_DATA,
  output logic [6:0] SEG,
  output logic [3:0] DIG,
  output logic [3:0] EL_OUT,
  output logic       UPDATED
);

  localparam logic [15:0] PCNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_END = 16'(BLANK_CYC);
  localparam logic [6:0]  SEG_OFF   = 7'h7F;
  localparam logic [3:0]  DIG_OFF   = 4'hF;

  logic [2:0]  r_prev_latch;
  logic [3:0]  r_el;
  logic [7:0]  r_d1;
  logic [7:0]  r_d2;
  logic [15:0] r_pcnt;
  logic [1:0]  r_idx;
  logic [6:0]  r_seg_hold;
  logic        r_fall_any;
  logic [6:0]  r_seg;
  logic [3:0]  r_dig;
  logic [3:0]  r_el_out;
  logic        r_updated;

  logic [2:0]  w_fall;
  logic        w_wrap;
  logic        w_blank;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg_next;
  logic [3:0]  w_dig_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
`ifdef LED_HEX_EN
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
`else
      default: seg = SEG_OFF;
`endif
    endcase
    return seg;
  endfunction

  assign w_fall  = r_prev_latch & ~LED_LATCH;
  assign w_wrap  = (r_pcnt == PCNT_LAST);
  assign w_blank = (r_pcnt < BLANK_END);

  // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_nibble = r_d1[3:0];
    case (r_idx)
      2'd0: w_nibble = r_d1[3:0];
      2'd1: w_nibble = r_d1[7:4];
      2'd2: w_nibble = r_d2[3:0];
      2'd3: w_nibble = r_d2[7:4];
      default: w_nibble = r_d1[3:0];
    endcase
  end

  // Segments are only re-decoded while blanked, so a capture never glitches a lit digit.
  assign w_seg_next = w_blank ? seg_decode(w_nibble) : r_seg_hold;
  assign w_dig_next = w_blank ? DIG_OFF : ~(4'b0001 << r_idx);

  // NOTE: reset is sampled only on the clock edge (synchronous), and all state uses <=.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_prev_latch <= 3'b111;
      r_el         <= 4'h0;
      r_d1         <= 8'h00;
      r_d2         <= 8'h00;
      r_pcnt       <= 16'd0;
      r_idx        <= 2'd0;
      r_seg_hold   <= SEG_OFF;
      r_fall_any   <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_el_out     <= 4'h0;
      r_updated    <= 1'b0;
    end else begin
      r_prev_latch <= LED_LATCH;
      if (w_fall[0]) r_el <= LED_DATA[3:0];
      if (w_fall[1]) r_d1 <= LED_DATA;
      if (w_fall[2]) r_d2 <= LED_DATA;

      r_fall_any <= |w_fall;
      r_updated  <= r_fall_any;

      r_pcnt <= w_wrap ? 16'd0 : r_pcnt + 16'd1;
      if (w_wrap) r_idx <= r_idx + 2'd1;

      // Scanning runs regardless of SYSTEM_TYPE so the display is current when enabled.
      r_seg_hold <= w_seg_next;
      r_seg      <= SYSTEM_TYPE ? w_seg_next : SEG_OFF;
      r_dig      <= SYSTEM_TYPE ? w_dig_next : DIG_OFF;
      r_el_out   <= SYSTEM_TYPE ? r_el : 4'h0;
    end
  end

  assign SEG     = r_seg;
  assign DIG     = r_dig;
  assign EL_OUT  = r_el_out;
  assign UPDATED = r_updated;

endmodule

// File: tb/tb_neo_led_scan.sv
// Self-checking bench for neo_led_scan: latch captures are scoreboarded against UPDATED,
// and the scanned display is compared to a cycle-count model of the slot sequence.
module tb_neo_led_scan;

  localparam int SD = 8;
  localparam int BL = 2;

`ifdef LED_HEX_EN
  localparam logic [6:0] DEC [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`else
  localparam logic [6:0] DEC [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
`endif

  logic       clk = 1'b0;
  logic       nreset;
  logic       sys_type;
  logic [2:0] led_latch;
  logic [7:0] led_data;
  logic [6:0] seg;
  logic [3:0] dig;
  logic [3:0] el_out;
  logic       updated;

  always #5 clk = ~clk;

  neo_led_scan #(.SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .CLK         (clk),
    .nRESET      (nreset),
    .SYSTEM_TYPE (sys_type),
    .LED_LATCH   (led_latch),
    .LED_DATA    (led_data),
    .SEG         (seg),
    .DIG         (dig),
    .EL_OUT      (el_out),
    .UPDATED     (updated)
  );

  typedef struct {
    logic [2:0] mask;
    logic [7:0] data;
    int         due;
  } upd_t;

  upd_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         k        = 0;
  logic [7:0] m_d1;
  logic [7:0] m_d2;
  logic [3:0] m_el;
  logic [6:0] m_snap;
  logic [2:0] cur_latch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [3:0] nib(input int id);
    case (id)
      0:       return m_d1[3:0];
      1:       return m_d1[7:4];
      2:       return m_d2[3:0];
      default: return m_d2[7:4];
    endcase
  endfunction

  task automatic do_checks();
    int         pc;
    int         id;
    upd_t       it;
    logic [3:0] exp_dig;
    if (k == 0) begin
      check("rst_dig", dig, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_el", el_out, 4'h0);
      check("rst_upd", updated, 1'b0);
      return;
    end
    pc = (k - 1) % SD;
    id = ((k - 1) / SD) % 4;
    if (sb.size() > 0 && sb[0].due == k) begin
      it = sb.pop_front();
      check("upd_pulse", updated, 1'b1);
      if (it.mask[0]) m_el = it.data[3:0];
      if (it.mask[1]) m_d1 = it.data;
      if (it.mask[2]) m_d2 = it.data;
    end else begin
      check("upd_idle", updated, 1'b0);
    end
    check("el_out", el_out, sys_type ? m_el : 4'h0);
    if (pc == BL - 1) m_snap = DEC[nib(id)];
    if (!sys_type) begin
      check("off_dig", dig, 4'hF);
      check("off_seg", seg, 7'h7F);
    end else if (pc < BL) begin
      check("dig_blank", dig, 4'hF);
    end else begin
      exp_dig = ~(4'b0001 << id);
      check("dig_lit", dig, exp_dig);
      check("seg_lit", seg, m_snap);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!nreset) begin
      k      = 0;
      m_d1   = 8'h00;
      m_d2   = 8'h00;
      m_el   = 4'h0;
      m_snap = 7'b1000000;
      sb.delete();
    end else begin
      k++;
    end
    @(negedge clk);
    do_checks();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_latch(input logic [2:0] l, input logic [7:0] d);
    upd_t       it;
    logic [2:0] f;
    f         = cur_latch & ~l;
    led_latch = l;
    led_data  = d;
    cur_latch = l;
    if (f != 3'b000) begin
      it.mask = f;
      it.data = d;
      it.due  = k + 2;
      sb.push_back(it);
    end
  endtask

  initial begin
    logic [7:0] sweep [3];
    sweep     = '{8'h32, 8'h76, 8'h84};
    nreset    = 1'b0;
    sys_type  = 1'b1;
    led_latch = 3'b111;
    led_data  = 8'h00;
    cur_latch = 3'b111;
    m_d1      = 8'h00;
    m_d2      = 8'h00;
    m_el      = 4'h0;
    m_snap    = 7'b1000000;

    run(3);
    nreset = 1'b1;
    run(40);

    // Credit display 1 = 51, then hold the strobe low.
    drive_latch(3'b101, 8'h51);
    run(40);
    drive_latch(3'b111, 8'h00);
    run(2);

    // All three strobes fall together.
    drive_latch(3'b000, 8'h0A);
    run(40);
    drive_latch(3'b111, 8'h0A);
    run(2);

    // Console mode hides a capture, then switching back shows it.
    sys_type = 1'b0;
    drive_latch(3'b101, 8'h99);
    run(3);
    drive_latch(3'b111, 8'h99);
    run(40);
    sys_type = 1'b1;
    run(40);

    foreach (sweep[i]) begin
      drive_latch(3'b001, sweep[i]);
      run(2);
      drive_latch(3'b111, sweep[i]);
      run(34);
    end

    // Capture on the same edge as the prescaler wrap.
    for (int i = 0; i < SD && (k % SD) != SD - 1; i++) tick();
    drive_latch(3'b011, 8'hC6);
    run(3);
    drive_latch(3'b111, 8'hC6);
    run(34);

    // Reset in the middle of slot 2 after loading both displays.
    drive_latch(3'b001, 8'h47);
    run(3);
    drive_latch(3'b111, 8'h47);
    run(3);
    for (int i = 0; i < 4 * SD && (k % (4 * SD)) != 2 * SD + 5; i++) tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    run(40);

    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
